mm_sdram_arb: RTL

Arbiter and sequencer that shares the single external SDRAM port among several memory-mapped masters: DMG CPU bus, SD-card ROM loader, and VGA line fetcher. It grants requesters round-robin and runs one single-beat transaction at a time against the SDRAM controller. It returns read data and a one-cycle acknowledge to the winner, and aborts stalled transactions with an open-bus error response. It sits between the memory-map controller's slave decode and the SDRAM controller.

---
 rtl/mm_sdram_arb.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mm_sdram_arb.sv
// mm_sdram_arb
//   Shares the single external SDRAM port among NREQ memory-mapped masters
//   (0 = VGA line fetcher, 1 = DMG CPU bus, 2 = SD-card ROM loader).
//   Requests are granted round-robin. One single-beat access runs at a time,
//   sequenced IDLE -> BUSY -> DONE. If the SDRAM controller never answers,
//   the access is aborted with an open-bus (all ones) error response.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   req/we              per-requester level request and write enable
//   addr/wdata          packed per-requester address/write data (slice i)
//   ack                 one-hot, one-cycle completion pulse to the winner
//   err                 set with ack when the access timed out
//   rdata               read data of the last completed access
//   busy                high while a transaction is in progress
//   gnt_idx             index of the current or last winner
//   mem_req/we/addr/wdata  request towards the SDRAM controller (latched)
//   mem_ack/mem_rdata   SDRAM completion pulse and read data
module mm_sdram_arb #(
    parameter int NREQ        = 3,
    parameter int AW          = 23,
    parameter int DW          = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ-1:0]               we,
    input  logic [NREQ*AW-1:0]            addr,
    input  logic [NREQ*DW-1:0]            wdata,
    output logic [NREQ-1:0]               ack,
    output logic                          err,
    output logic [DW-1:0]                 rdata,
    output logic                          busy,
    output logic [$clog2(NREQ)-1:0]       gnt_idx,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [AW-1:0]                 mem_addr,
    output logic [DW-1:0]                 mem_wdata,
    input  logic                          mem_ack,
    input  logic [DW-1:0]                 mem_rdata
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;

    logic [IW-1:0] win;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // First set request bit searched upward from ptr+1 with wrap. The loop
    // walks from the farthest candidate to the nearest so the nearest set
    // bit is the last assignment and therefore wins.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   p);
        logic [IW-1:0] w;
        int            idx;
        w = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(p) + k) % NREQ;
            if (r[idx]) w = IW'(idx);
        end
        return w;
    endfunction

    always_comb begin
        win       = rr_pick(req, ptr);
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                win_we    = we[i];
                win_addr  = addr[i*AW +: AW];
                win_wdata = wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= IW'(NREQ - 1);
            cnt       <= '0;
            ack       <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            gnt_idx   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                // Arbitrate and latch the winner's access.
                S_IDLE: begin
                    ack <= '0;
                    err <= 1'b0;
                    if (|req) begin
                        mem_we    <= win_we;
                        mem_addr  <= win_addr;
                        mem_wdata <= win_wdata;
                        mem_req   <= 1'b1;
                        gnt_idx   <= win;
                        ptr       <= win;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= S_BUSY;
                    end
                end
                // Wait for the controller; mem_ack takes priority over timeout.
                S_BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        rdata   <= mem_rdata;
                        ack     <= NREQ'(1) << gnt_idx;
                        err     <= 1'b0;
                        state   <= S_DONE;
                    end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                        mem_req <= 1'b0;
                        rdata   <= '1;
                        ack     <= NREQ'(1) << gnt_idx;
                        err     <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // One-cycle completion; requests are ignored here so the
                // winner has time to drop req.
                S_DONE: begin
                    ack   <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    ack     <= '0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
